// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage and IF/ID pipeline register for the
//               pipelined RV32I core. Holds the PC, drives the instruction
//               memory address and presents the fetched word plus its
//               pre-sliced opcode/funct fields to decode one cycle later.
//               Handles hazard stalls, imem wait states and execute-stage
//               redirects, inserting NOP bubbles where required.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               imem_addr/rdata/ready - instruction memory (same-cycle read)
//               stall               - hazard unit hold request
//               pcsrc_e, target_e   - redirect request/target from execute
//               instr_d, op_d, funct3_d, funct7_d, pc_d, pcplus4_d, valid_d
//                                   - IF/ID register outputs
//               misalign_f          - pulse: redirect target low bits != 0
//               perf_fetched/perf_bubbles - IF/ID load counters
// Options     : FETCH_PERF_EN - when defined, the perf counters are built;
//               otherwise both counter outputs are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [31:0]              NOP_INSTR     = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     imem_ready,
    input  logic                     stall,
    input  logic                     pcsrc_e,
    input  logic [ADDRESS_WIDTH-1:0] target_e,
    output logic [31:0]              instr_d,
    output logic [6:0]               op_d,
    output logic [2:0]               funct3_d,
    output logic                     funct7_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pcplus4_d,
    output logic                     valid_d,
    output logic                     misalign_f,
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_bubbles
);

    localparam logic [ADDRESS_WIDTH-1:0] C_PC_INC = ADDRESS_WIDTH'(4);

    logic [ADDRESS_WIDTH-1:0] pc_f_q,         pc_f_d;
    logic [31:0]              ifid_instr_q,   ifid_instr_d;
    logic [ADDRESS_WIDTH-1:0] ifid_pc_q,      ifid_pc_d;
    logic [ADDRESS_WIDTH-1:0] ifid_pcplus4_q, ifid_pcplus4_d;
    logic                     ifid_valid_q,   ifid_valid_d;
    logic                     misalign_q,     misalign_d;
    logic [ADDRESS_WIDTH-1:0] w_pc_plus4;

    // Wraps modulo 2^ADDRESS_WIDTH by construction.
    assign w_pc_plus4 = pc_f_q + C_PC_INC;

    // Next-state selection: redirect > stall > imem wait > normal fetch.
    always_comb begin
        pc_f_d         = pc_f_q;
        ifid_instr_d   = ifid_instr_q;
        ifid_pc_d      = ifid_pc_q;
        ifid_pcplus4_d = ifid_pcplus4_q;
        ifid_valid_d   = ifid_valid_q;
        misalign_d     = 1'b0;

        if (pcsrc_e) begin
            // Redirect overrides stall and wait states; target low bits are
            // dropped and reported through misalign_f.
            pc_f_d         = {target_e[ADDRESS_WIDTH-1:2], 2'b00};
            ifid_instr_d   = NOP_INSTR;
            ifid_pc_d      = '0;
            ifid_pcplus4_d = '0;
            ifid_valid_d   = 1'b0;
            misalign_d     = |target_e[1:0];
        end else if (stall) begin
            // Hold everything, even when imem is also waiting.
        end else if (!imem_ready) begin
            ifid_instr_d   = NOP_INSTR;
            ifid_pc_d      = '0;
            ifid_pcplus4_d = '0;
            ifid_valid_d   = 1'b0;
        end else begin
            pc_f_d         = w_pc_plus4;
            ifid_instr_d   = imem_rdata;
            ifid_pc_d      = pc_f_q;
            ifid_pcplus4_d = w_pc_plus4;
            ifid_valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_q         <= RESET_PC;
            ifid_instr_q   <= NOP_INSTR;
            ifid_pc_q      <= '0;
            ifid_pcplus4_q <= '0;
            ifid_valid_q   <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            pc_f_q         <= pc_f_d;
            ifid_instr_q   <= ifid_instr_d;
            ifid_pc_q      <= ifid_pc_d;
            ifid_pcplus4_q <= ifid_pcplus4_d;
            ifid_valid_q   <= ifid_valid_d;
            misalign_q     <= misalign_d;
        end
    end

    assign imem_addr  = pc_f_q;
    assign instr_d    = ifid_instr_q;
    assign op_d       = ifid_instr_q[6:0];
    assign funct3_d   = ifid_instr_q[14:12];
    assign funct7_d   = ifid_instr_q[30];
    assign pc_d       = ifid_pc_q;
    assign pcplus4_d  = ifid_pcplus4_q;
    assign valid_d    = ifid_valid_q;
    assign misalign_f = misalign_q;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] bubbles_q, bubbles_d;
    logic        w_load_valid;
    logic        w_load_bubble;

    // Same priority as the IF/ID update: a stalled cycle loads nothing.
    assign w_load_valid  = !pcsrc_e && !stall && imem_ready;
    assign w_load_bubble = pcsrc_e || (!stall && !imem_ready);

    always_comb begin
        fetched_d = fetched_q;
        bubbles_d = bubbles_q;
        if (w_load_valid) begin
            fetched_d = fetched_q + 32'd1;
        end
        if (w_load_bubble) begin
            bubbles_d = bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_fetched = '0;
    assign perf_bubbles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage. Inputs change
//               1 time unit after the rising edge and outputs are checked at
//               that point, once the registered state has settled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        pcsrc_e;
    logic [31:0] target_e;
    logic [31:0] instr_d;
    logic [6:0]  op_d;
    logic [2:0]  funct3_d;
    logic        funct7_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic        misalign_f;
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;

    int vecs = 0;
    int errs = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .imem_ready   (imem_ready),
        .stall        (stall),
        .pcsrc_e      (pcsrc_e),
        .target_e     (target_e),
        .instr_d      (instr_d),
        .op_d         (op_d),
        .funct3_d     (funct3_d),
        .funct7_d     (funct7_d),
        .pc_d         (pc_d),
        .pcplus4_d    (pcplus4_d),
        .valid_d      (valid_d),
        .misalign_f   (misalign_f),
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset: bubble in IF/ID, PC at 0, NOP fields decoded.
    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; pcsrc_e = 1'b0; imem_ready = 1'b1;
        target_e = 32'h0; imem_rdata = 32'hFFFF_FFFF;
        step();
        rst = 1'b0;
        vecs++;
        if ({imem_addr, instr_d, pc_d, pcplus4_d, valid_d, misalign_f} !== {32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_state: got addr=%h instr=%h pc=%h pc4=%h v=%b mis=%b, want addr=0 instr=%h pc=0 pc4=0 v=0 mis=0",
                     imem_addr, instr_d, pc_d, pcplus4_d, valid_d, misalign_f, NOP);
        end
        vecs++;
        if ({op_d, funct3_d, funct7_d} !== {7'b0010011, 3'b000, 1'b0}) begin
            errs++;
            $display("FAIL reset_fields: got op=%b f3=%b f7=%b, want 0010011/000/0", op_d, funct3_d, funct7_d);
        end
        vecs++;
        if ({perf_fetched, perf_bubbles} !== 64'h0) begin
            errs++;
            $display("FAIL reset_perf: got fetched=%0d bubbles=%0d, want 0/0", perf_fetched, perf_bubbles);
        end
    endtask

    // Two back-to-back fetches from address 0.
    task automatic test_fetch();
        imem_rdata = 32'h0050_0093;
        step();
        vecs++;
        if ({imem_addr, instr_d, pc_d, pcplus4_d, valid_d, op_d} !== {32'h4, 32'h0050_0093, 32'h0, 32'h4, 1'b1, 7'b0010011}) begin
            errs++;
            $display("FAIL fetch0: got addr=%h instr=%h pc=%h pc4=%h v=%b op=%b, want 4/00500093/0/4/1/0010011",
                     imem_addr, instr_d, pc_d, pcplus4_d, valid_d, op_d);
        end
        imem_rdata = 32'h00A0_0113;
        step();
        vecs++;
        if ({imem_addr, instr_d, pc_d, pcplus4_d, valid_d} !== {32'h8, 32'h00A0_0113, 32'h4, 32'h8, 1'b1}) begin
            errs++;
            $display("FAIL fetch1: got addr=%h instr=%h pc=%h pc4=%h v=%b, want 8/00a00113/4/8/1",
                     imem_addr, instr_d, pc_d, pcplus4_d, valid_d);
        end
    endtask

    // Three stall cycles at pc_f=8, then fetch of an R-type with funct7[5]=1.
    task automatic test_stall();
        stall = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            vecs++;
            if ({imem_addr, instr_d, pc_d, valid_d} !== {32'h8, 32'h00A0_0113, 32'h4, 1'b1}) begin
                errs++;
                $display("FAIL stall_hold[%0d]: got addr=%h instr=%h pc=%h v=%b, want 8/00a00113/4/1",
                         i, imem_addr, instr_d, pc_d, valid_d);
            end
        end
        stall = 1'b0;
        imem_rdata = 32'h4020_8133;
        step();
        vecs++;
        if ({imem_addr, instr_d, pc_d, op_d, funct3_d, funct7_d} !== {32'hC, 32'h4020_8133, 32'h8, 7'b0110011, 3'b000, 1'b1}) begin
            errs++;
            $display("FAIL stall_release: got addr=%h instr=%h pc=%h op=%b f3=%b f7=%b, want c/40208133/8/0110011/000/1",
                     imem_addr, instr_d, pc_d, op_d, funct3_d, funct7_d);
        end
    endtask

    // Two wait states at pc_f=C, a fetch, then stall together with wait.
    task automatic test_imem_wait();
        imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            vecs++;
            if ({imem_addr, instr_d, pc_d, valid_d} !== {32'hC, NOP, 32'h0, 1'b0}) begin
                errs++;
                $display("FAIL wait_bubble[%0d]: got addr=%h instr=%h pc=%h v=%b, want c/00000013/0/0",
                         i, imem_addr, instr_d, pc_d, valid_d);
            end
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h00C0_0213;
        step();
        vecs++;
        if ({imem_addr, instr_d, pc_d, valid_d} !== {32'h10, 32'h00C0_0213, 32'hC, 1'b1}) begin
            errs++;
            $display("FAIL wait_resume: got addr=%h instr=%h pc=%h v=%b, want 10/00c00213/c/1",
                     imem_addr, instr_d, pc_d, valid_d);
        end
        stall = 1'b1;
        imem_ready = 1'b0;
        step();
        vecs++;
        if ({imem_addr, instr_d, pc_d, valid_d} !== {32'h10, 32'h00C0_0213, 32'hC, 1'b1}) begin
            errs++;
            $display("FAIL stall_over_wait: got addr=%h instr=%h pc=%h v=%b, want 10/00c00213/c/1",
                     imem_addr, instr_d, pc_d, valid_d);
        end
        stall = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 32'h0100_0293;
        step();
        vecs++;
        if ({imem_addr, instr_d, pc_d, valid_d} !== {32'h14, 32'h0100_0293, 32'h10, 1'b1}) begin
            errs++;
            $display("FAIL wait_after_stall: got addr=%h instr=%h pc=%h v=%b, want 14/01000293/10/1",
                     imem_addr, instr_d, pc_d, valid_d);
        end
    endtask

    // Aligned redirect to 0x40: bubble then target instruction.
    task automatic test_redirect();
        pcsrc_e = 1'b1;
        target_e = 32'h0000_0040;
        imem_rdata = 32'h1111_1111;
        step();
        pcsrc_e = 1'b0;
        vecs++;
        if ({imem_addr, instr_d, valid_d, misalign_f} !== {32'h40, NOP, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL redirect_bubble: got addr=%h instr=%h v=%b mis=%b, want 40/00000013/0/0",
                     imem_addr, instr_d, valid_d, misalign_f);
        end
        imem_rdata = 32'h0010_0313;
        step();
        vecs++;
        if ({imem_addr, instr_d, pc_d, pcplus4_d, valid_d} !== {32'h44, 32'h0010_0313, 32'h40, 32'h44, 1'b1}) begin
            errs++;
            $display("FAIL redirect_target: got addr=%h instr=%h pc=%h pc4=%h v=%b, want 44/00100313/40/44/1",
                     imem_addr, instr_d, pc_d, pcplus4_d, valid_d);
        end
    endtask

    // Misaligned redirect with stall and wait both asserted: redirect wins.
    task automatic test_redirect_stall();
        pcsrc_e = 1'b1;
        stall = 1'b1;
        imem_ready = 1'b0;
        target_e = 32'h0000_0102;
        step();
        pcsrc_e = 1'b0;
        stall = 1'b0;
        imem_ready = 1'b1;
        vecs++;
        if ({imem_addr, instr_d, valid_d, misalign_f} !== {32'h100, NOP, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL redirect_over_stall: got addr=%h instr=%h v=%b mis=%b, want 100/00000013/0/1",
                     imem_addr, instr_d, valid_d, misalign_f);
        end
        imem_rdata = 32'h0020_0393;
        step();
        vecs++;
        if ({imem_addr, pc_d, valid_d, misalign_f} !== {32'h104, 32'h100, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL misalign_pulse_end: got addr=%h pc=%h v=%b mis=%b, want 104/100/1/0",
                     imem_addr, pc_d, valid_d, misalign_f);
        end
    endtask

    // PC wrap at the top of the address space.
    task automatic test_wrap();
        pcsrc_e = 1'b1;
        target_e = 32'hFFFF_FFFC;
        step();
        pcsrc_e = 1'b0;
        imem_rdata = 32'h0030_0413;
        step();
        vecs++;
        if ({imem_addr, pc_d, pcplus4_d, valid_d, misalign_f} !== {32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL pc_wrap: got addr=%h pc=%h pc4=%h v=%b mis=%b, want 0/fffffffc/0/1/0",
                     imem_addr, pc_d, pcplus4_d, valid_d, misalign_f);
        end
    endtask

    // Counters: 10 fetches, 1 redirect, 2 waits; reset during stall+redirect.
    task automatic test_perf();
        logic [31:0] exp_f;
        logic [31:0] exp_b;
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            imem_rdata = 32'h0000_0013 | (32'(i) << 20);
            step();
        end
        pcsrc_e = 1'b1;
        target_e = 32'h0000_0200;
        step();
        pcsrc_e = 1'b0;
        imem_ready = 1'b0;
        step();
        step();
        imem_ready = 1'b1;
`ifdef FETCH_PERF_EN
        exp_f = 32'd10;
        exp_b = 32'd3;
`else
        exp_f = 32'd0;
        exp_b = 32'd0;
`endif
        vecs++;
        if ({perf_fetched, perf_bubbles} !== {exp_f, exp_b}) begin
            errs++;
            $display("FAIL perf_counts: got fetched=%0d bubbles=%0d, want %0d/%0d",
                     perf_fetched, perf_bubbles, exp_f, exp_b);
        end
        rst = 1'b1;
        stall = 1'b1;
        pcsrc_e = 1'b1;
        target_e = 32'h0000_0303;
        step();
        rst = 1'b0;
        stall = 1'b0;
        pcsrc_e = 1'b0;
        vecs++;
        if ({perf_fetched, perf_bubbles} !== 64'h0) begin
            errs++;
            $display("FAIL perf_reset: got fetched=%0d bubbles=%0d, want 0/0", perf_fetched, perf_bubbles);
        end
        vecs++;
        if ({imem_addr, instr_d, valid_d, misalign_f} !== {32'h0, NOP, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid_redirect: got addr=%h instr=%h v=%b mis=%b, want 0/00000013/0/0",
                     imem_addr, instr_d, valid_d, misalign_f);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_imem_wait();
        test_redirect();
        test_redirect_stall();
        test_wrap();
        test_perf();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the pipelined RV32I core. Holds the program counter, drives the instruction-memory address, and presents the fetched instruction plus its pre-sliced opcode/funct fields to the decode-side control unit one cycle later. It handles hazard-unit stalls, instruction-memory wait states and branch/jump redirects from execute, and inserts NOP bubbles as required.

## Interface
- ADDRESS_WIDTH, 32, width of PC and all address/target ports
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  ADDRESS_WIDTH  fetch address, equal to current PC
- imem_rdata  in  32  instruction word at imem_addr, same-cycle
- imem_ready  in  1  imem_rdata valid this cycle; 0 = wait state
- stall  in  1  hazard unit: hold PC and IF/ID
- pcsrc_e  in  1  execute: branch taken or jump, redirect fetch
- target_e  in  ADDRESS_WIDTH  redirect target from execute
- instr_d  out  32  IF/ID instruction
- op_d  out  7  instr_d[6:0]
- funct3_d  out  3  instr_d[14:12]
- funct7_d  out  1  instr_d[30]
- pc_d  out  ADDRESS_WIDTH  PC of instr_d
- pcplus4_d  out  ADDRESS_WIDTH  pc_d + 4
- valid_d  out  1  instr_d is a real instruction (0 = bubble)
- misalign_f  out  1  one-cycle pulse: redirect target had [1:0] != 0
- perf_fetched  out  32  count of valid instructions loaded into IF/ID
- perf_bubbles  out  32  count of bubbles loaded into IF/ID

## Operation
- Registered state: pc_f, IF/ID register (instr, pc, pcplus4, valid), misalign_f, perf counters.
- Per-cycle priority, highest first:
  - rst: pc_f <= RESET_PC; IF/ID <= bubble (instr NOP_INSTR, pc/pcplus4 0, valid 0); misalign_f <= 0; counters <= 0.
  - pcsrc_e: pc_f <= {target_e[ADDRESS_WIDTH-1:2], 2'b00}; IF/ID <= bubble; misalign_f <= |target_e[1:0]. Redirect overrides stall and imem wait.
  - stall: pc_f and IF/ID hold.
  - !imem_ready: pc_f holds; IF/ID <= bubble.
  - otherwise: IF/ID <= {imem_rdata, pc_f, pc_f+4, valid 1}; pc_f <= pc_f + 4.
- misalign_f is 0 on every cycle without a redirect.
- PC arithmetic is modulo 2^ADDRESS_WIDTH; pc_f+4 from 32'hFFFF_FFFC wraps to 0 without flags.
- op_d, funct3_d, funct7_d are combinational slices of registered instr_d; they read NOP fields (0010011/000/0) during bubbles.
- Bubble contents are fixed so the control unit decodes a bubble as addi x0 with no side effects.

## Timing
- imem_addr = pc_f, combinational from register, stable all cycle.
- Fetch latency: word at imem_addr in cycle N appears on instr_d in cycle N+1.
- Redirect latency: pcsrc_e in cycle N -> imem_addr = target in N+1 -> target instruction on instr_d in N+2; instr_d in N+1 is a bubble.
- Stall in cycle N: instr_d/pc_d in N+1 equal those in N; imem_addr unchanged.
- Reset: after rst high in cycle N, cycle N+1 shows imem_addr = RESET_PC, valid_d 0, instr_d NOP_INSTR, misalign_f 0, counters 0. Reset mid-stall or mid-redirect has identical outcome.
- Simultaneous stall and !imem_ready: stall wins, IF/ID holds (no bubble).

## Configuration
- FETCH_PERF_EN defined: perf_fetched increments on each cycle IF/ID loads valid 1; perf_bubbles increments on each cycle IF/ID loads a bubble (redirect or imem wait, not reset, not stall); both wrap at 2^32, clear on rst.
- FETCH_PERF_EN undefined: no counter logic; perf_fetched and perf_bubbles tied to 0.

## Test plan
- Reset then imem_ready=1, rdata 32'h00500093, 32'h00A00113 -> instr_d shows them on cycles 1,2; pc_d 0, 4; pcplus4_d 4, 8; valid_d 1; op_d 7'b0010011.
- pcsrc_e=1, target_e=32'h0000_0040 in cycle N -> cycle N+1 valid_d 0, instr_d 32'h00000013, imem_addr 0x40; cycle N+2 pc_d 0x40.
- stall=1 for 3 cycles with pc_f=0x8 -> imem_addr stays 0x8, instr_d/pc_d frozen; after release, pc_d 0x8 next cycle.
- imem_ready=0 for 2 cycles at pc_f=0xC -> two bubbles (valid_d 0), imem_addr stays 0xC; stall=1 concurrently with imem_ready=0 -> IF/ID holds instead.
- pcsrc_e=1 with stall=1, target_e=32'h0000_0102 -> redirect wins; imem_addr 0x100, misalign_f pulses 1 for one cycle, IF/ID bubble.
- FETCH_PERF_EN: 10 normal fetches, 1 redirect, 2 wait cycles -> perf_fetched 10, perf_bubbles 3; rst -> both 0. Undefined: both 0 throughout.
